cbd_sched: RTL and testbench

Round-robin scheduler that shares one external 8-bit loadable down counter (CBD38-class: LD/D/EN/CAI in, CAO out) among N_REQ requesters. Each requester asks for a delay of CNT+1 counter ticks. The block grants one requester, loads its count, and enables counting until terminal count. It then acknowledges the requester and moves to the next. It sits between request logic and the shared counter macro. The counter's own CD and PS are driven elsewhere; PS is held low by the system.

---
 rtl/cbd_sched.sv | 155 +++++++++++++++
 tb/tb_cbd_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_sched.sv
// Round-robin scheduler sharing one external loadable down counter among N_REQ requesters.
// Each grant loads the requester's count, runs the counter to terminal count, then acknowledges.
module cbd_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int TMO   = 257
) (
  input  logic               CLK,
  input  logic               CDN,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ*W-1:0] CNT,
  output logic [N_REQ-1:0]   GNT,
  output logic [N_REQ-1:0]   ACK,
  output logic               ABT,
  output logic               ERR,
  output logic               BUSY,
  output logic               LD,
  output logic [W-1:0]       D,
  output logic               EN,
  output logic               CAI,
  input  logic               TC
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_r;
  logic [PW-1:0]      ptr_r;
  logic [PW-1:0]      g_r;
  logic [TW-1:0]      tmo_cnt_r;
  logic [N_REQ-1:0]   gnt_r;
  logic [N_REQ-1:0]   ack_r;
  logic               abt_r;
  logic               err_r;
  logic               busy_r;
  logic               ld_r;
  logic [W-1:0]       d_r;
  logic               en_r;
  logic               pick_valid_s;
  logic [PW-1:0]      pick_idx_s;
  logic [PW-1:0]      ptr_next_s;

  // First requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    int j;
    j            = 0;
    pick_valid_s = 1'b0;
    pick_idx_s   = {PW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      j            = int'(ptr_r) + i;
      j            = (j >= N_REQ) ? (j - N_REQ) : j;
      pick_idx_s   = (REQ[j] && !pick_valid_s) ? PW'(j) : pick_idx_s;
      pick_valid_s = pick_valid_s | REQ[j];
    end
  end

  assign ptr_next_s = (g_r == PW'(N_REQ - 1)) ? {PW{1'b0}} : (g_r + PW'(1));

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_r   <= S_IDLE;
      ptr_r     <= {PW{1'b0}};
      g_r       <= {PW{1'b0}};
      tmo_cnt_r <= {TW{1'b0}};
      gnt_r     <= {N_REQ{1'b0}};
      ack_r     <= {N_REQ{1'b0}};
      abt_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      ld_r      <= 1'b0;
      d_r       <= {W{1'b0}};
      en_r      <= 1'b0;
    end else begin
      ack_r <= {N_REQ{1'b0}};
      abt_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pick_valid_s) begin
            g_r     <= pick_idx_s;
            gnt_r   <= ONE_HOT0 << pick_idx_s;
            d_r     <= CNT[int'(pick_idx_s)*W +: W];
            ld_r    <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          ld_r      <= 1'b0;
          en_r      <= 1'b1;
          tmo_cnt_r <= {TW{1'b0}};
          state_r   <= S_RUN;
        end
        S_RUN: begin
          // Terminal count wins over abort, abort wins over timeout.
          if (TC) begin
            en_r    <= 1'b0;
            ack_r   <= gnt_r;
            ptr_r   <= ptr_next_s;
            state_r <= S_DONE;
          end else if (!REQ[g_r]) begin
            en_r    <= 1'b0;
            abt_r   <= 1'b1;
            gnt_r   <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= ptr_next_s;
            state_r <= S_IDLE;
          end else if (tmo_cnt_r == TW'(TMO - 1)) begin
            en_r    <= 1'b0;
            err_r   <= 1'b1;
            gnt_r   <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= ptr_next_s;
            state_r <= S_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        S_DONE: begin
          gnt_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          en_r    <= 1'b0;
          ld_r    <= 1'b0;
          gnt_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign GNT  = gnt_r;
  assign ACK  = ack_r;
  assign ABT  = abt_r;
  assign ERR  = err_r;
  assign BUSY = busy_r;
  assign LD   = ld_r;
  assign D    = d_r;
  assign EN   = en_r;
  assign CAI  = en_r;

endmodule

// File: tb/tb_cbd_sched.sv
// Directed bench for cbd_sched with a behavioural down-counter model and an ACK scoreboard.
module tb_cbd_sched;
  logic        CLK = 1'b0;
  logic        CDN;
  logic [3:0]  REQ;
  logic [31:0] CNT;
  logic [3:0]  GNT, ACK;
  logic        ABT, ERR, BUSY, LD, EN, CAI, TC;
  logic [7:0]  D;

  logic [7:0]  q = 8'hAA;
  logic        tc_kill = 1'b0;
  int          cyc = 0;
  int          t0 = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [3:0] ack;
    int         at;
  } exp_t;
  exp_t sb[$];

  cbd_sched #(.N_REQ(4), .W(8), .TMO(257)) dut (
    .CLK(CLK), .CDN(CDN), .REQ(REQ), .CNT(CNT), .GNT(GNT), .ACK(ACK), .ABT(ABT),
    .ERR(ERR), .BUSY(BUSY), .LD(LD), .D(D), .EN(EN), .CAI(CAI), .TC(TC)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Shared 8-bit loadable down counter
  always @(posedge CLK) begin
    if (LD) q <= D;
    else if (EN && CAI) q <= q - 8'd1;
  end
  assign TC = !tc_kill && (q == 8'd0) && CAI && EN;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_ack(input int budget);
    exp_t e;
    int n;
    n = 0;
    step();
    while (ACK == 4'b0000 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=%0h expected=none", ACK);
    end else begin
      e = sb.pop_front();
      chk("ack_vec", {28'd0, ACK}, {28'd0, e.ack});
      chk("ack_cycle", cyc - t0, e.at);
    end
  endtask

  initial begin
    int n;
    CDN = 1'b0;
    REQ = 4'b1111;
    CNT = {4{8'd1}};
    repeat (3) begin
      step();
      chk("reset_outs", {10'd0, GNT, ACK, ABT, ERR, BUSY, LD, EN, CAI, D}, 32'd0);
    end
    REQ = 4'b0000;
    step();
    CDN = 1'b1;
    step();

    // single request, count 3
    CNT[7:0] = 8'd3;
    REQ = 4'b0001;
    t0 = cyc;
    sb.push_back('{4'b0001, 6});
    step();
    chk("load_ld", LD, 1);
    chk("load_d", D, 3);
    chk("load_gnt", GNT, 1);
    chk("load_en", EN, 0);
    chk("load_busy", BUSY, 1);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("run_en_cai_ld", {EN, CAI, LD}, 3'b110);
    end
    wait_ack(10);
    REQ = 4'b0000;
    chk("done_en", EN, 0);
    step();
    chk("idle_busy", BUSY, 0);
    chk("idle_gnt", GNT, 0);
    chk("idle_ack", ACK, 0);

    // zero count on requester 2
    CNT[23:16] = 8'd0;
    REQ = 4'b0100;
    t0 = cyc;
    sb.push_back('{4'b0100, 3});
    wait_ack(10);
    REQ = 4'b0000;
    repeat (3) step();
    chk("wrap_q", q, 8'hFF);
    chk("wrap_busy", BUSY, 0);
    chk("wrap_ack", ACK, 0);
    chk("d_hold", D, 0);

    // round robin from a fresh pointer
    CDN = 1'b0;
    step();
    CDN = 1'b1;
    step();
    CNT = {4{8'd1}};
    REQ = 4'b1111;
    t0 = cyc;
    sb.push_back('{4'b0001, 4});
    sb.push_back('{4'b0010, 9});
    sb.push_back('{4'b0100, 14});
    sb.push_back('{4'b1000, 19});
    sb.push_back('{4'b0001, 24});
    for (int i = 0; i < 5; i++) begin
      wait_ack(20);
      if (i == 2) REQ = 4'b1001;
      if (i == 4) REQ = 4'b0000;
    end
    step();

    // abort of requester 1 in its third RUN cycle
    CNT[15:8] = 8'd10;
    REQ = 4'b0010;
    t0 = cyc;
    repeat (4) step();
    chk("abort_pre_en", EN, 1);
    chk("abort_pre_gnt", GNT, 4'b0010);
    REQ = 4'b0000;
    step();
    chk("abort_abt", ABT, 1);
    chk("abort_en", EN, 0);
    chk("abort_gnt", GNT, 0);
    chk("abort_ack", ACK, 0);
    chk("abort_busy", BUSY, 0);
    REQ = 4'b0101;
    t0 = cyc;
    sb.push_back('{4'b0100, 4});
    step();
    chk("abort_pulse_end", ABT, 0);
    chk("ptr_after_abort", GNT, 4'b0100);
    wait_ack(10);
    REQ = 4'b0000;
    step();

    // reset asserted mid-RUN
    CNT[7:0] = 8'd10;
    REQ = 4'b0001;
    repeat (3) step();
    chk("midrun_en", EN, 1);
    #2 CDN = 1'b0;
    #1;
    chk("midrun_rst_outs", {GNT, LD, EN, BUSY}, 7'd0);
    REQ = 4'b0000;
    step();
    CDN = 1'b1;
    repeat (4) begin
      step();
      chk("midrun_no_ack_abt", {ACK, ABT}, 5'd0);
    end

    // full-range count does not time out
    CNT[7:0] = 8'hFF;
    REQ = 4'b0001;
    t0 = cyc;
    sb.push_back('{4'b0001, 258});
    wait_ack(300);
    REQ = 4'b0000;
    chk("fullcnt_err", ERR, 0);
    step();

    // timeout with terminal count suppressed
    tc_kill = 1'b1;
    CNT[7:0] = 8'd3;
    REQ = 4'b0001;
    t0 = cyc;
    n = 0;
    step();
    while (!ERR && n < 400) begin
      step();
      n++;
    end
    chk("tmo_cycle", cyc - t0, 259);
    chk("tmo_err", ERR, 1);
    chk("tmo_gnt", GNT, 0);
    chk("tmo_ack", ACK, 0);
    step();
    chk("regrant_gnt", GNT, 4'b0001);
    chk("regrant_ld", LD, 1);
    REQ = 4'b0000;
    tc_kill = 1'b0;
    repeat (4) step();
    chk("err_sticky", ERR, 1);
    chk("err_busy", BUSY, 0);
    CDN = 1'b0;
    step();
    chk("err_cleared", ERR, 0);
    CDN = 1'b1;
    step();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
